// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO manager: FSM encoding, Clause 22 opcodes and frame layout.
// Latency: n/a (package only).
// Backpressure: n/a.
package mdio_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_TA   = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Clause 22 opcodes
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam int PRE_LEN = 32;

  // Basic mode status register and its link-status bit
  localparam logic [4:0] BMSR_ADDR = 5'd1;
  localparam int         LINK_BIT  = 2;

  // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA (MSB first).
  // For reads the TA/DATA part is never driven, so its content is irrelevant.
  function automatic logic [31:0] frame_word(input logic       we,
                                             input logic [4:0] phy,
                                             input logic [4:0] regad,
                                             input logic [15:0] wdata);
    frame_word = {2'b01, (we ? OP_WR : OP_RD), phy, regad, 2'b10, wdata};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: divides clk by 2*CLK_DIV and flags the clk in which MDC rises or falls.
// Latency: first MDC rise CLK_DIV clks after en goes high.
// Backpressure: none; en low holds MDC low and clears the divider.
// Ports: clk, reset (async active-low), en (run MDC), mdc (MDC level),
//        rise/fall (strobes true in the clk whose closing edge toggles mdc).
module mdio_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = en && (cnt == 8'(CLK_DIV - 1));
  assign rise = wrap && !mdc;
  assign fall = wrap && mdc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 8'd0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= 8'd0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= 8'd0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_manager.sv
// MDIO (Clause 22) manager: serves host read/write requests and autonomously polls BMSR for link.
// Latency: busy 1 clk after a request in IDLE; a frame lasts 64 MDC periods plus one DONE clk.
// Backpressure: usr_req is a level sampled only in IDLE; host must drop it on usr_ack or it repeats.
// Ports: clk, reset (async active-low); host side usr_req/usr_we/usr_reg/usr_wdata -> usr_ack/usr_rdata;
//        poll_en -> link_up; busy; pins e_mdc, e_mdio, mdio_en (1 = drive pad), mdio_rx.
module mdio_manager
  import mdio_pkg::*;
#(
  parameter int          CLK_DIV     = 25,
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [25:0] POLL_PERIOD = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        usr_req,
  input  logic        usr_we,
  input  logic [4:0]  usr_reg,
  input  logic [15:0] usr_wdata,
  output logic        usr_ack,
  output logic [15:0] usr_rdata,
  input  logic        poll_en,
  output logic        link_up,
  output logic        busy,
  output logic        e_mdc,
  output logic        e_mdio,
  output logic        mdio_en,
  input  logic        mdio_rx
);

  logic [2:0]  state, nxt_state;
  logic [4:0]  bit_cnt;
  logic        last_bit;
  logic [31:0] shreg;
  logic [15:0] rx_shift;
  logic        we_q, poll_q;
  logic [25:0] poll_cnt;
  logic        poll_pend, poll_tick;
  logic        grant_host, grant_poll;
  logic        mdc_rise, mdc_fall;

  assign busy       = (state == ST_PRE) || (state == ST_HDR) ||
                      (state == ST_TA)  || (state == ST_DATA);
  assign usr_ack    = (state == ST_DONE) && !poll_q;
  assign poll_tick  = poll_en && (poll_cnt == POLL_PERIOD - 26'd1);
  // Fixed priority: host beats a pending poll.
  assign grant_host = (state == ST_IDLE) && usr_req;
  assign grant_poll = (state == ST_IDLE) && !usr_req && poll_pend;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .reset(reset),
    .en   (busy),
    .mdc  (e_mdc),
    .rise (mdc_rise),
    .fall (mdc_fall)
  );

  // Segment length and successor for each frame phase.
  always_comb begin
    last_bit  = 1'b0;
    nxt_state = state;
    case (state)
      ST_PRE:  begin last_bit = (bit_cnt == 5'(PRE_LEN - 1)); nxt_state = ST_HDR;  end
      ST_HDR:  begin last_bit = (bit_cnt == 5'd13);           nxt_state = ST_TA;   end
      ST_TA:   begin last_bit = (bit_cnt == 5'd1);            nxt_state = ST_DATA; end
      ST_DATA: begin last_bit = (bit_cnt == 5'd15);           nxt_state = ST_DONE; end
      default: ;
    endcase
  end

  // Bits advance on MDC falling strobes; read data is captured on rising strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 5'd0;
      shreg     <= 32'd0;
      rx_shift  <= 16'd0;
      we_q      <= 1'b0;
      poll_q    <= 1'b0;
      usr_rdata <= 16'd0;
      link_up   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_host || grant_poll) begin
            state   <= ST_PRE;
            bit_cnt <= 5'd0;
            we_q    <= grant_host && usr_we;
            poll_q  <= grant_poll;
            shreg   <= frame_word(grant_host && usr_we, PHY_ADDR,
                                  grant_host ? usr_reg : BMSR_ADDR, usr_wdata);
          end
        end
        ST_PRE, ST_HDR, ST_TA, ST_DATA: begin
          if (mdc_rise && (state == ST_DATA))
            rx_shift <= {rx_shift[14:0], mdio_rx};
          if (mdc_fall) begin
            if (state != ST_PRE)
              shreg <= {shreg[30:0], 1'b0};
            if (last_bit) begin
              state   <= nxt_state;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
            // Last data bit was sampled on the preceding rise, so rx_shift is complete here.
            if (last_bit && (state == ST_DATA)) begin
              if (poll_q)
                link_up <= rx_shift[LINK_BIT];
              else if (!we_q)
                usr_rdata <= rx_shift;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pad outputs are registered from the current phase, so they change one clk after the MDC fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_mdio  <= 1'b1;
      mdio_en <= 1'b0;
    end else begin
      case (state)
        ST_PRE: begin
          e_mdio  <= 1'b1;
          mdio_en <= 1'b1;
        end
        ST_HDR: begin
          e_mdio  <= shreg[31];
          mdio_en <= 1'b1;
        end
        ST_TA, ST_DATA: begin
          e_mdio  <= we_q ? shreg[31] : 1'b1;
          mdio_en <= we_q;
        end
        default: begin
          e_mdio  <= 1'b1;
          mdio_en <= 1'b0;
        end
      endcase
    end
  end

  // Poll timer: one tick every POLL_PERIOD clks; a tick while pending does not stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt  <= 26'd0;
      poll_pend <= 1'b0;
    end else if (!poll_en) begin
      poll_cnt  <= 26'd0;
      poll_pend <= 1'b0;
    end else begin
      poll_cnt <= poll_tick ? 26'd0 : poll_cnt + 26'd1;
      if (grant_poll)
        poll_pend <= 1'b0;
      else if (poll_tick)
        poll_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdio_manager.sv
// Self-checking bench for mdio_manager: PHY model on the pins, scoreboard of expected frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdio_manager;

  localparam int          CLK_DIV  = 2;
  localparam logic [4:0]  PHY_ADDR = 5'd1;
  localparam logic [25:0] PP       = 26'd1000;
  localparam int          LIM      = 3000;

  typedef struct packed {
    logic [63:0] bits;
    logic [63:0] mask;
    logic [63:0] en;
    logic        host;
    logic        rd;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        usr_req, usr_we, poll_en;
  logic [4:0]  usr_reg;
  logic [15:0] usr_wdata;
  logic        usr_ack, link_up, busy, e_mdc, e_mdio, mdio_en, mdio_rx;
  logic [15:0] usr_rdata;

  int errs = 0, checks = 0;
  int ack_cnt = 0, host_cnt = 0;
  exp_t exp_q[$];

  logic [15:0] phy_regs [0:31];
  logic [15:0] model    [0:31];
  logic [63:0] cap_bits, cap_en;
  int          k, per_bad, cyc, last_rise;
  logic        prev_mdc, prev_b;

  always #5 clk = ~clk;

  mdio_manager #(.CLK_DIV(CLK_DIV), .PHY_ADDR(PHY_ADDR), .POLL_PERIOD(PP)) dut (
    .clk(clk), .reset(reset), .usr_req(usr_req), .usr_we(usr_we), .usr_reg(usr_reg),
    .usr_wdata(usr_wdata), .usr_ack(usr_ack), .usr_rdata(usr_rdata), .poll_en(poll_en),
    .link_up(link_up), .busy(busy), .e_mdc(e_mdc), .e_mdio(e_mdio), .mdio_en(mdio_en),
    .mdio_rx(mdio_rx)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Expected Clause 22 frame straight from the field definitions.
  function automatic exp_t mk(input bit host, input bit we, input logic [4:0] r, input logic [15:0] d);
    exp_t e;
    e.bits  = {32'hFFFF_FFFF, 2'b01, (we ? 2'b01 : 2'b10), PHY_ADDR, r, 2'b10, d};
    e.mask  = we ? {64{1'b1}} : {{46{1'b1}}, 18'd0};
    e.en    = e.mask;
    e.host  = host;
    e.rd    = !we;
    e.rdata = d;
    return e;
  endfunction

  // PHY model: captures pins on each MDC rise, answers reads, commits completed writes.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      k = 0; per_bad = 0; prev_mdc = 1'b0; prev_b = 1'b0; mdio_rx = 1'b1;
    end else begin
      if (busy && !prev_b) begin
        k = 0; per_bad = 0; cap_bits = '0; cap_en = '0;
      end
      if (!busy && prev_b && k == 64 && cap_bits[29:28] == 2'b01)
        phy_regs[cap_bits[22:18]] = cap_bits[15:0];
      if (e_mdc && !prev_mdc) begin
        if (k > 0 && (cyc - last_rise) != 2 * CLK_DIV) per_bad++;
        last_rise = cyc;
        if (k < 64) begin
          cap_bits[63-k] = e_mdio;
          cap_en[63-k]   = mdio_en;
        end
        k++;
      end
      if (k >= 48 && k < 64 && cap_bits[29:28] == 2'b10)
        mdio_rx = phy_regs[cap_bits[22:18]][15-(k-48)];
      else
        mdio_rx = 1'b1;
      prev_mdc = e_mdc;
      prev_b   = busy;
    end
  end

  // Monitor: each frame end (busy falling = DONE clk) is scored against the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    logic pb;
    if (!reset) begin
      pb = 1'b0;
    end else begin
      if (usr_ack) ack_cnt++;
      if (pb && !busy) begin
        if (exp_q.size() == 0) begin
          errs++; checks++;
          $display("FAIL unexpected_frame: got frame with reg %h, required none", cap_bits[22:18]);
        end else begin
          e = exp_q.pop_front();
          chk("rise_count", 64'(k), 64'd64);
          chk("mdc_period_errs", 64'(per_bad), 64'd0);
          chk("frame_bits", cap_bits & e.mask, e.bits & e.mask);
          chk("mdio_en_pattern", cap_en, e.en);
          chk("usr_ack_at_done", 64'(usr_ack), 64'(e.host));
          if (e.host && e.rd) chk("usr_rdata", 64'(usr_rdata), 64'(e.rdata));
          if (!e.host) chk("link_up", 64'(link_up), 64'(e.rdata[2]));
        end
      end
      pb = busy;
    end
  end

  task automatic host_txn(input bit we, input logic [4:0] r, input logic [15:0] d, input bit with_poll);
    int n;
    exp_q.push_back(mk(1'b1, we, r, we ? d : model[r]));
    if (we) model[r] = d;
    if (with_poll) exp_q.push_back(mk(1'b0, 1'b0, 5'd1, model[1]));
    @(negedge clk);
    usr_req = 1'b1; usr_we = we; usr_reg = r; usr_wdata = d;
    @(posedge clk); #1;
    chk("grant_latency", 64'(busy), 64'd1);
    // Fields must have been latched at grant.
    usr_we = 1'($urandom); usr_reg = 5'($urandom); usr_wdata = 16'($urandom);
    n = 0;
    while (!usr_ack && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", 64'(usr_ack), 64'd1);
    if (usr_ack) host_cnt++;
    usr_req = 1'b0;
  endtask

  task automatic wait_empty(input string nm, input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n, bc;
    reset = 1'b0; usr_req = 1'b0; usr_we = 1'b0; usr_reg = 5'd0; usr_wdata = 16'd0; poll_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      model[i]    = 16'($urandom);
      phy_regs[i] = model[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_e_mdc", 64'(e_mdc), 64'd0);
    chk("rst_e_mdio", 64'(e_mdio), 64'd1);
    chk("rst_mdio_en", 64'(mdio_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_usr_ack", 64'(usr_ack), 64'd0);
    chk("rst_usr_rdata", 64'(usr_rdata), 64'd0);
    chk("rst_link_up", 64'(link_up), 64'd0);
    reset = 1'b1;
    bc = 0;
    repeat (50) begin @(negedge clk); if (busy) bc++; end
    chk("idle_after_reset", 64'(bc), 64'd0);

    // Directed write and read, then random traffic.
    host_txn(1'b1, 5'd0, 16'h1200, 1'b0);
    model[2] = 16'h0022; phy_regs[2] = 16'h0022;
    host_txn(1'b0, 5'd2, 16'h0000, 1'b0);
    for (int i = 0; i < 24; i++)
      host_txn(1'($urandom), 5'($urandom_range(0, 31)), 16'($urandom), 1'b0);

    // Reset in the middle of data bit 7 of a write.
    @(negedge clk);
    usr_req = 1'b1; usr_we = 1'b1; usr_reg = 5'd4; usr_wdata = 16'hA5C3;
    n = 0;
    while (k < 56 && n < LIM) begin @(negedge clk); n++; end
    chk("reached_data_bit7", 64'(k >= 56), 64'd1);
    reset = 1'b0; usr_req = 1'b0;
    #1;
    chk("midrst_e_mdc", 64'(e_mdc), 64'd0);
    chk("midrst_mdio_en", 64'(mdio_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_e_mdio", 64'(e_mdio), 64'd1);
    chk("midrst_rdata", 64'(usr_rdata), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_idle", 64'(busy), 64'd0);
    host_txn(1'b1, 5'd4, 16'hA5C3, 1'b0);
    host_txn(1'b0, 5'd4, 16'h0000, 1'b0);

    // Autonomous polls: link up, then link down.
    model[1] = 16'h0004; phy_regs[1] = 16'h0004;
    exp_q.push_back(mk(1'b0, 1'b0, 5'd1, model[1]));
    @(negedge clk); poll_en = 1'b1;
    wait_empty("poll1_done", LIM);
    chk("link_up_after_poll1", 64'(link_up), 64'd1);
    model[1] = 16'h0000; phy_regs[1] = 16'h0000;
    exp_q.push_back(mk(1'b0, 1'b0, 5'd1, model[1]));
    wait_empty("poll2_done", LIM);
    chk("link_up_after_poll2", 64'(link_up), 64'd0);
    poll_en = 1'b0;

    // Host request in the clk of the poll tick: host first, then exactly one poll.
    model[1] = 16'hFFFF; phy_regs[1] = 16'hFFFF;
    @(negedge clk); poll_en = 1'b1;
    repeat (int'(PP) - 2) @(negedge clk);
    host_txn(1'b1, 5'd7, 16'($urandom), 1'b1);
    wait_empty("race_poll_done", LIM);
    poll_en = 1'b0;
    bc = 0;
    repeat (300) begin @(negedge clk); if (busy) bc++; end
    chk("no_second_poll", 64'(bc), 64'd0);
    chk("ack_count", 64'(ack_cnt), 64'(host_cnt));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/mdio_manager.md
MDIO_MANAGER -- requirements
Module: mdio_manager

Interface
REQ-001 Parameter CLK_DIV, default 25: system-clock cycles per MDC half-period; legal range 2..255.
REQ-002 Parameter PHY_ADDR, default 5'd1: PHY address placed in every frame.
REQ-003 Parameter POLL_PERIOD, default 26'd50_000_000: system-clock cycles between autonomous status polls.
REQ-004 Port clk, input, 1: single system clock.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port usr_req, input, 1: host transaction request, level; sampled only while idle.
REQ-007 Port usr_we, input, 1: 1 = write, 0 = read; qualified by usr_req.
REQ-008 Port usr_reg, input, 5: PHY register address.
REQ-009 Port usr_wdata, input, 16: write data.
REQ-010 Port usr_ack, output, 1: one-clk pulse when a host transaction completes.
REQ-011 Port usr_rdata, output, 16: read data; valid from usr_ack onward, held until the next host read completes.
REQ-012 Port poll_en, input, 1: enables the autonomous poll of register 1 (BMSR).
REQ-013 Port link_up, output, 1: BMSR bit 2 from the last completed poll.
REQ-014 Port busy, output, 1: high from grant through the final data bit.
REQ-015 Ports e_mdc (output, 1), e_mdio (output, 1), mdio_en (output, 1, 1 = drive pad), mdio_rx (input, 1): MDIO pins.

Function
REQ-016 e_mdc toggles every CLK_DIV clks only while busy; it idles low.
REQ-017 e_mdio changes one clk after the MDC falling edge; mdio_rx is sampled on the clk in which MDC rises.
REQ-018 Frame format is Clause 22: 32 preamble ones, ST=01, OP (01 write / 10 read), PHY_ADDR, REGAD, TA, 16 data bits, MSB first; 64 MDC periods total.
REQ-019 FSM states and transitions: IDLE -> PRE (32 bits) -> HDR (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE (1 clk) -> IDLE.
REQ-020 Write TA drives 1,0; read TA and DATA set mdio_en=0; mdio_en=1 in PRE/HDR and in write TA/DATA, and 0 in IDLE.
REQ-021 Arbitration in IDLE uses fixed priority: a host request wins over a pending poll.
REQ-022 A poll tick sets poll_pend; poll_pend clears when the poll is granted; a repeated tick while pending does not queue a second poll.
REQ-023 The poll timer free-runs while poll_en=1; deasserting poll_en clears the timer and poll_pend but does not abort a poll in flight.
REQ-024 Grant latency is 1 clk from IDLE with a request present to busy=1.
REQ-025 usr_ack asserts in DONE only for host transactions; a completed poll updates link_up and does not assert usr_ack.
REQ-026 A usr_req held across a poll is served immediately after that poll's DONE; the host deasserts usr_req on usr_ack, otherwise the request repeats.
REQ-027 Request fields (we, reg, wdata) are latched at grant; later input changes do not affect the frame in flight.

Reset
REQ-028 Reset asserted, including mid-frame, forces IDLE with e_mdc=0, e_mdio=1, mdio_en=0, busy=0, usr_ack=0, usr_rdata=0, link_up=0, poll_pend=0, and all counters 0.
REQ-029 After reset release, no frame starts without a request or poll tick.

Structure
REQ-030 The shared package mdio_pkg holds the FSM state encoding, opcode constants (OP_WR=2'b01, OP_RD=2'b10), the preamble length (32) and the BMSR address and link-bit index.
REQ-031 MDC generation is the single sub-module mdio_clk_gen (CLK_DIV counter with rise/fall strobes); the FSM, arbiter and poll timer remain in mdio_manager.

Verification
REQ-032 Host write reg 0, data 16'h1200 -> 64 MDC periods; bits after preamble = 0101 00001 00000 10 0001001000000000; one usr_ack; mdio_en=1 throughout.
REQ-033 Host read reg 2 with PHY model returning 16'h0022 -> mdio_en=0 from TA through DATA; usr_rdata=16'h0022 at usr_ack.
REQ-034 POLL_PERIOD=1000, poll_en=1, PHY BMSR=16'h0004 -> link_up=1 after the first poll; BMSR=16'h0000 -> link_up=0 after the next poll; usr_ack never pulses.
REQ-035 usr_req and poll tick in the same clk -> host frame first, poll frame immediately after its DONE; exactly one poll.
REQ-036 Reset asserted at data bit 7 of a write -> same-clk e_mdc=0, mdio_en=0, busy=0; after release, a fresh usr_req yields a complete 64-bit frame.
REQ-037 CLK_DIV=2 -> MDC period is 4 clks; all frames remain bit-correct.
